// File: rtl/cpu_pkg.sv
// Shared types and defaults for the CPU memory subsystem.
package cpu_pkg;

  localparam int CPU_DATA_W = 32;

  // Who owns the read data returning from the shared memory this cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } owner_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive data grants that overtook a waiting fetch and forces the
// fetch through once the count reaches STARVE_MAX.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_gnt_w,
  input  logic i_gnt_w,
  output logic force_i
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_req || i_gnt_w) begin
      cnt_d = '0;
    end else if (d_gnt_w && (cnt_q != CNT_W'(STARVE_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_i = i_req && (cnt_q == CNT_W'(STARVE_MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with a
// one-cycle read latency; data has priority, bounded by a starvation guard.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  logic   force_i;
  logic   i_gnt_w, d_gnt_w;
  owner_e state_q, state_d;

  arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .d_gnt_w (d_gnt_w),
    .i_gnt_w (i_gnt_w),
    .force_i (force_i)
  );

  // NOTE: grants and read returns are gated by rst combinationally so every
  // output is quiet for the whole reset cycle, not only after the edge.
  assign d_gnt_w = !rst && d_req && !force_i;
  assign i_gnt_w = !rst && i_req && (!d_req || force_i);
  assign i_gnt   = i_gnt_w;
  assign d_gnt   = d_gnt_w;

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt_w) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt_w) begin
      m_en    = 1'b1;
      m_addr  = i_addr;
      m_wdata = d_wdata;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (i_gnt_w)              state_d = RD_I;
    else if (d_gnt_w && !d_we) state_d = RD_D;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  assign i_rvalid = !rst && (state_q == RD_I);
  assign d_rvalid = !rst && (state_q == RD_D);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, collision, starvation, write, reset.
module tb_mem_arbiter;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we;
  logic [DATA_W-1:0] i_addr, d_addr, d_wdata, m_rdata;
  logic              i_gnt, i_rvalid, d_gnt, d_rvalid, m_en, m_we;
  logic [DATA_W-1:0] i_rdata, d_rdata, m_addr, m_wdata;

  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en = 1'b0;

  mem_arbiter #(.DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .m_en     (m_en),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_i_gnt"},    32'(i_gnt),    32'd0);
    check({tag, "_d_gnt"},    32'(d_gnt),    32'd0);
    check({tag, "_m_en"},     32'(m_en),     32'd0);
    check({tag, "_m_we"},     32'(m_we),     32'd0);
    check({tag, "_m_addr"},   m_addr,        32'd0);
    check({tag, "_m_wdata"},  m_wdata,       32'd0);
    check({tag, "_i_rvalid"}, 32'(i_rvalid), 32'd0);
    check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'd0);
    check({tag, "_i_rdata"},  i_rdata,       32'd0);
    check({tag, "_d_rdata"},  d_rdata,       32'd0);
  endtask

  // Every-cycle protocol monitor: mutual exclusion and no grant without request.
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_mutex",   32'(i_gnt & d_gnt),  32'd0);
      check("mon_i_noreq", 32'(i_gnt & ~i_req), 32'd0);
      check("mon_d_noreq", 32'(d_gnt & ~d_req), 32'd0);
    end
  end

  // Expected {i_gnt,d_gnt} under continuous contention: D,D,D,D,I,D.
  logic [1:0] starve_exp [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

  initial begin
    rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h10; d_addr = 32'h20; d_wdata = 32'hAAAA_5555; m_rdata = 32'hFFFF_FFFF;
    mon_en = 1'b1;

    // Reset with both requests high: everything quiet.
    repeat (2) next_cycle();
    @(negedge clk);
    check_quiet("rst_hold");

    // Fetch-only in the first cycle after reset.
    next_cycle();
    rst = 1'b0; d_req = 1'b0; i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    check("fetch_i_gnt",  32'(i_gnt), 32'd1);
    check("fetch_m_en",   32'(m_en),  32'd1);
    check("fetch_m_we",   32'(m_we),  32'd0);
    check("fetch_m_addr", m_addr,     32'h10);
    check("fetch_m_wdata", m_wdata,   32'hAAAA_5555);
    next_cycle();
    i_req = 1'b0; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("fetch_i_rvalid", 32'(i_rvalid), 32'd1);
    check("fetch_i_rdata",  i_rdata,       32'hDEAD_BEEF);
    check("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
    check("fetch_d_rdata",  d_rdata,       32'd0);

    // Collision with an empty starvation count: data wins.
    next_cycle();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    @(negedge clk);
    check("coll_d_gnt",  32'(d_gnt), 32'd1);
    check("coll_i_gnt",  32'(i_gnt), 32'd0);
    check("coll_m_addr", m_addr,     32'h20);
    check("coll_m_we",   32'(m_we),  32'd0);
    next_cycle();
    i_req = 1'b0; d_req = 1'b0; m_rdata = 32'h1234_5678;
    @(negedge clk);
    check("coll_d_rvalid", 32'(d_rvalid), 32'd1);
    check("coll_d_rdata",  d_rdata,       32'h1234_5678);
    check("coll_i_rvalid", 32'(i_rvalid), 32'd0);
    check("coll_i_rdata",  i_rdata,       32'd0);

    // Starvation: six cycles of continuous contention.
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h100; d_addr = 32'h200;
      m_rdata = 32'hC000_0000 + 32'(i);
      @(negedge clk);
      check($sformatf("starve_gnt%0d", i), 32'({i_gnt, d_gnt}), 32'(starve_exp[i]));
      check($sformatf("starve_addr%0d", i), m_addr,
            (starve_exp[i] == 2'b10) ? 32'h100 : 32'h200);
      if (i > 0) begin
        check($sformatf("starve_rv%0d", i), 32'({i_rvalid, d_rvalid}),
              32'(starve_exp[i-1]));
      end
    end
    // Return of the final data read, then the fetch's return one cycle earlier.
    next_cycle();
    i_req = 1'b0; d_req = 1'b0; m_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    check("starve_last_d_rdata", d_rdata, 32'h0BAD_F00D);

    // Write: completes at grant, no read return.
    next_cycle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h55;
    @(negedge clk);
    check("wr_d_gnt",   32'(d_gnt), 32'd1);
    check("wr_m_en",    32'(m_en),  32'd1);
    check("wr_m_we",    32'(m_we),  32'd1);
    check("wr_m_addr",  m_addr,     32'h8);
    check("wr_m_wdata", m_wdata,    32'h55);
    next_cycle();
    d_req = 1'b0; d_we = 1'b0; m_rdata = 32'h7777_7777;
    @(negedge clk);
    check_quiet("wr_after");

    // Starvation count reaches 4, then reset while a data read is in flight.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
      @(negedge clk);
      check($sformatf("pre_rst_gnt%0d", i), 32'({i_gnt, d_gnt}), 32'b01);
    end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_quiet("rst_mid_d");
    // Count was cleared: contention grants data first, not the fetch.
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", 32'({i_gnt, d_gnt}), 32'b01);

    // Fetch granted, then reset the next cycle: its data never returns.
    next_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    check("rmr_i_gnt", 32'(i_gnt), 32'd1);
    next_cycle();
    rst = 1'b1; m_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_quiet("rmr_rst");
    next_cycle();
    rst = 1'b0; i_req = 1'b0;
    @(negedge clk);
    check("rmr_after_i_rvalid", 32'(i_rvalid), 32'd0);

    next_cycle();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data and address width of every port.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive data grants while a fetch waits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_req  input  1  SHALL carry the instruction-fetch request.
REQ-006 i_addr  input  DATA_W  SHALL carry the fetch address.
REQ-007 i_gnt  output  1  SHALL signal that the fetch is accepted this cycle.
REQ-008 i_rvalid  output  1  SHALL signal that fetch read data is valid.
REQ-009 i_rdata  output  DATA_W  SHALL carry fetch read data.
REQ-010 d_req  input  1  SHALL carry the data-access request.
REQ-011 d_we  input  1  SHALL select the access type: 1 = write, 0 = read.
REQ-012 d_addr  input  DATA_W  SHALL carry the data address.
REQ-013 d_wdata  input  DATA_W  SHALL carry the data write value.
REQ-014 d_gnt  output  1  SHALL signal that the data access is accepted this cycle.
REQ-015 d_rvalid  output  1  SHALL signal that data read data is valid.
REQ-016 d_rdata  output  DATA_W  SHALL carry data read data.
REQ-017 m_en, m_we  output  1 each  SHALL be the enable and write-enable of the shared single-port memory.
REQ-018 m_addr, m_wdata  output  DATA_W each  SHALL be the shared-memory address and write data.
REQ-019 m_rdata  input  DATA_W  SHALL be the shared-memory read data, valid 1 cycle after a read with m_en=1.

Function
REQ-020 Handshake: a requester SHALL hold req, addr, we and wdata stable until it sees gnt=1; gnt SHALL be combinational from req in the same cycle.
REQ-021 At most one of i_gnt and d_gnt SHALL be 1 in any cycle; a grant SHALL only be given while the matching req is 1.
REQ-022 In a granted cycle: m_en=1; m_addr = granted address, unmodified; m_we = d_we for a data grant, 0 for a fetch grant; m_wdata = d_wdata.
REQ-023 In a cycle with no grant: m_en=0, m_we=0, m_addr=0, m_wdata=0.
REQ-024 Priority: data SHALL win over fetch, except when starve_cnt == STARVE_MAX and i_req=1, in which case fetch SHALL win.
REQ-025 starve_cnt: +1 on a data grant while i_req=1; cleared on any fetch grant or when i_req=0; saturates at STARVE_MAX.
REQ-026 FSM owner register, states IDLE, RD_I, RD_D, updated every cycle:
- fetch grant -> RD_I
- data read grant -> RD_D
- data write grant or no grant -> IDLE
REQ-027 In state RD_I: i_rvalid=1 and i_rdata=m_rdata. In state RD_D: d_rvalid=1 and d_rdata=m_rdata. Otherwise both rvalid=0 and both rdata=0.
REQ-028 Read latency SHALL be exactly 1 cycle from grant to rvalid; writes SHALL complete at grant and produce no rvalid.
REQ-029 Back-to-back grants SHALL be allowed every cycle; the rvalid for grant N SHALL coincide with grant N+1.
REQ-030 When both requesters request continuously, the grant sequence SHALL be STARVE_MAX data grants, then 1 fetch grant, repeating.

Reset
REQ-031 While rst=1, all outputs SHALL be 0, the FSM SHALL be IDLE and starve_cnt SHALL be 0, regardless of req inputs.
REQ-032 A read granted in the cycle before rst is sampled high SHALL produce no rvalid.
REQ-033 The first grant after reset SHALL be possible in the first cycle with rst=0.

Structure
REQ-034 The FSM state encodings (IDLE=2'd0, RD_I=2'd1, RD_D=2'd2) and the DATA_W default SHALL live in the shared cpu_pkg package.
REQ-035 The starvation counter SHALL be one sub-module, arb_starve_ctr (inputs: clk, rst, i_req, d_gnt_w, i_gnt_w; output: force_i); all other logic SHALL be flat.

Verification
REQ-036 Fetch-only: i_req=1, i_addr=0x10, m_rdata=0xDEADBEEF on the next cycle -> i_gnt=1 in cycle 0; i_rvalid=1 with i_rdata=0xDEADBEEF in cycle 1.
REQ-037 Collision: i_req=d_req=1 (d_we=0, d_addr=0x20) with starve_cnt=0 -> d_gnt=1, i_gnt=0, m_addr=0x20; d_rvalid=1 in the next cycle.
REQ-038 Starvation: i_req and d_req held high 6 cycles, STARVE_MAX=4 -> grants D,D,D,D,I,D.
REQ-039 Write: d_req=1, d_we=1, d_addr=0x8, d_wdata=0x55 -> m_en=m_we=1, m_addr=0x8, m_wdata=0x55; no d_rvalid in the following cycle.
REQ-040 Reset mid-read: fetch granted in cycle 0, rst=1 in cycle 1 -> i_rvalid=0 in cycle 1, all outputs 0; starve_cnt=0 afterwards.
REQ-041 Assertion on every cycle of all scenarios: i_gnt & d_gnt never both 1, and gnt never 1 without its req.
